// File: rtl/q3_vec_sequencer_if.sv
// q3 sequencer bus: stimulus out, model responses in, sweep results out.
interface q3_vec_sequencer_if;
  logic        start;
  logic        abort;
  logic        x;
  logic        y;
  logic        z;
  logic        m;
  logic        s_in;
  logic        p_in;
  logic        l_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_vec;
  logic [15:0] p_map;

  modport master (
    output start, abort, s_in, p_in, l_in,
    input  x, y, z, m, busy, done, pass,
    input  err_cnt, first_err_vec, p_map
  );

  modport slave (
    input  start, abort, s_in, p_in, l_in,
    output x, y, z, m, busy, done, pass,
    output err_cnt, first_err_vec, p_map
  );
endinterface

// File: rtl/q3_vec_sequencer.sv
// Exhaustive 16-vector sweep of the q3 models with settle delay,
// mismatch counting and p-output capture.
module q3_vec_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input logic               clk,
  input logic               rst,
  q3_vec_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SLAST = 4'(SETTLE - 1);

  state_t      state;
  state_t      next;
  logic [3:0]  vec;
  logic [3:0]  scnt;
  logic [4:0]  err_q;
  logic [3:0]  first_q;
  logic [15:0] pmap_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        mism;
  logic [4:0]  err_nxt;

  // Case inequality so an X/Z on either model output is a mismatch.
  assign mism    = (bus.l_in !== bus.s_in);
  assign err_nxt = err_q + 5'(mism);

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (bus.start) next = WAIT;
      WAIT: begin
        if (bus.abort)        next = IDLE;
        else if (scnt == SLAST) next = CHECK;
      end
      CHECK: begin
        if (bus.abort)        next = IDLE;
        else if (vec == 4'hF) next = DONE;
        else                  next = WAIT;
      end
      DONE:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec     <= '0;
      scnt    <= '0;
      err_q   <= '0;
      first_q <= '0;
      pmap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      busy_q <= (next == WAIT) || (next == CHECK);
      done_q <= (next == DONE);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            vec     <= '0;
            scnt    <= '0;
            err_q   <= '0;
            first_q <= '0;
            pmap_q  <= '0;
            pass_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.abort) pass_q <= 1'b0;
          else           scnt   <= scnt + 4'd1;
        end
        CHECK: begin
          if (bus.abort) begin
            pass_q <= 1'b0;
          end else begin
            err_q <= err_nxt;
            if (mism && err_q == 5'd0)
              first_q <= vec;
            pmap_q[vec] <= bus.p_in;
            if (vec == 4'hF) begin
              pass_q <= (err_nxt == 5'd0);
            end else begin
              vec  <= vec + 4'd1;
              scnt <= '0;
            end
          end
        end
        DONE: pass_q <= (err_q == 5'd0);
        default: ;
      endcase
    end
  end

  assign bus.x             = vec[3];
  assign bus.y             = vec[2];
  assign bus.z             = vec[1];
  assign bus.m             = vec[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_vec = first_q;
  assign bus.p_map         = pmap_q;

endmodule

// File: tb/tb_q3_vec_sequencer.sv
// Directed bench for q3_vec_sequencer with a result scoreboard.
// Three instances cover SETTLE = 2, 1 and 15.
module tb_q3_vec_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q3_vec_sequencer_if b2 ();
  q3_vec_sequencer_if b1 ();
  q3_vec_sequencer_if b15 ();

  q3_vec_sequencer #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .bus(b2)
  );
  q3_vec_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  q3_vec_sequencer #(.SETTLE(15)) dut15 (
    .clk(clk), .rst(rst), .bus(b15)
  );

  typedef struct {
    logic [4:0]  err;
    logic [3:0]  first;
    logic        pass;
    logic [15:0] pmap;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  logic        inv_s;
  logic [15:0] inj;
  logic [15:0] xm;
  logic        xv;

  function automatic logic pf(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  always_comb begin
    logic [3:0] v;
    logic s;
    v = {b2.x, b2.y, b2.z, b2.m};
    s = (^v) ^ inv_s;
    b2.s_in = s;
    b2.p_in = pf(v);
    b2.l_in = xm[v] ? xv : (inj[v] ? ~s : s);
  end

  always_comb begin
    logic [3:0] v;
    v = {b1.x, b1.y, b1.z, b1.m};
    b1.s_in = ^v;
    b1.l_in = ^v;
    b1.p_in = pf(v);
  end

  always_comb begin
    logic [3:0] v;
    v = {b15.x, b15.y, b15.z, b15.m};
    b15.s_in = ^v;
    b15.l_in = ^v;
    b15.p_in = pf(v);
  end

  function automatic exp_t model();
    exp_t e;
    logic [3:0] v;
    logic s;
    logic l;
    e.err   = '0;
    e.first = '0;
    e.pmap  = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      s = (^v) ^ inv_s;
      l = xm[v] ? xv : (inj[v] ? ~s : s);
      if (l !== s) begin
        if (e.err == 5'd0) e.first = v;
        e.err = e.err + 5'd1;
      end
      e.pmap[v] = pf(v);
    end
    e.pass = (e.err == 5'd0);
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vec2();
    return 32'({b2.x, b2.y, b2.z, b2.m});
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_vec"},   vec2(), 0);
    chk({tag, "_busy"},  32'(b2.busy), 0);
    chk({tag, "_done"},  32'(b2.done), 0);
    chk({tag, "_pass"},  32'(b2.pass), 0);
    chk({tag, "_err"},   32'(b2.err_cnt), 0);
    chk({tag, "_first"}, 32'(b2.first_err_vec), 0);
    chk({tag, "_pmap"},  32'(b2.p_map), 0);
  endtask

  // mode 0: full sweep, 1: abort in CHECK of vector 7, 2: reset at vector 9
  task automatic run2(input int mode);
    int k;
    exp_t e;
    logic seen;
    @(negedge clk);
    b2.start = 1'b1;
    sbq.push_back(model());
    @(posedge clk);
    @(negedge clk);
    b2.start = 1'b0;
    k = 0;
    seen = 1'b0;
    chk("busy_rise", 32'(b2.busy), 1);
    chk("vec0", vec2(), 0);
    while (k < 300) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (mode == 0) begin
        chk("vec_seq", vec2(), (k / 3 > 15) ? 15 : k / 3);
        if (b2.done) begin
          seen = 1'b1;
          break;
        end
      end else if (mode == 1) begin
        if (k == 23) b2.abort = 1'b1;
        if (k == 24) begin
          b2.abort = 1'b0;
          break;
        end
      end else begin
        if (k == 10) b2.start = 1'b1;
        if (k == 11) begin
          b2.start = 1'b0;
          chk("no_restart", vec2(), 3);
          chk("no_restart_busy", 32'(b2.busy), 1);
        end
        if (k == 28) rst = 1'b1;
        if (k == 29) begin
          rst = 1'b0;
          break;
        end
      end
    end
    e = sbq.pop_front();
    if (mode == 0) begin
      chk("done_seen", 32'(seen), 1);
      chk("sweep_len", k + 1, 49);
      chk("busy_fall", 32'(b2.busy), 0);
      chk("pass", 32'(b2.pass), 32'(e.pass));
      chk("err_cnt", 32'(b2.err_cnt), 32'(e.err));
      chk("first_err", 32'(b2.first_err_vec), 32'(e.first));
      chk("p_map", 32'(b2.p_map), 32'(e.pmap));
      b2.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b2.start = 1'b0;
      chk("done_pulse", 32'(b2.done), 0);
      chk("start_in_done", 32'(b2.busy), 0);
      chk("pass_hold", 32'(b2.pass), 32'(e.pass));
      chk("vec_hold_f", vec2(), 15);
    end else if (mode == 1) begin
      chk("abort_busy", 32'(b2.busy), 0);
      chk("abort_pass", 32'(b2.pass), 0);
      chk("abort_vec", vec2(), 7);
      chk("abort_err", 32'(b2.err_cnt), 32'(e.err));
      chk("abort_plo", 32'(b2.p_map[6:0]), 32'(e.pmap[6:0]));
      seen = 1'b0;
      repeat (60) begin
        @(negedge clk);
        if (b2.done) seen = 1'b1;
      end
      chk("abort_nodone", 32'(seen), 0);
      chk("abort_phi", 32'(b2.p_map[15:8]), 0);
      chk("abort_idle", 32'(b2.busy), 0);
    end else begin
      chk_reset("midrst");
    end
  endtask

  initial begin
    int k;
    int len1;
    int len15;
    rst      = 1'b1;
    b2.start = 1'b0;
    b2.abort = 1'b0;
    b1.start = 1'b0;
    b1.abort = 1'b0;
    b15.start = 1'b0;
    b15.abort = 1'b0;
    inv_s = 1'b0;
    inj   = '0;
    xm    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");

    run2(0);

    inj = 16'h1020;
    run2(0);
    chk("inj_err", 32'(b2.err_cnt), 2);
    chk("inj_first", 32'(b2.first_err_vec), 5);

    inj   = '0;
    inv_s = 1'b1;
    xm    = 16'h0008;
    run2(0);

    inv_s = 1'b0;
    xm    = '0;
    run2(1);

    run2(2);

    @(negedge clk);
    b1.start  = 1'b1;
    b15.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.start  = 1'b0;
    b15.start = 1'b0;
    len1  = 0;
    len15 = 0;
    k = 0;
    while (k < 400 && (len1 == 0 || len15 == 0)) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (b1.done && len1 == 0)   len1  = k + 1;
      if (b15.done && len15 == 0) len15 = k + 1;
    end
    chk("len_s1", len1, 33);
    chk("len_s15", len15, 257);
    chk("pass_s1", 32'(b1.pass), 1);
    chk("pass_s15", 32'(b15.pass), 1);
    inv_s = 1'b0;
    inj = '0;
    xm = '0;
    chk("pmap_s1", 32'(b1.p_map), 32'(model().pmap));
    chk("pmap_s15", 32'(b15.p_map), 32'(model().pmap));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/q3_vec_sequencer.md
# q3_vec_sequencer

Exhaustive stimulus sequencer and checker for the 4-input q3 combinational function. On `start` it steps all 16 input combinations {x,y,z,m} = 0..15 into the gate-level model and the UDP model. After each vector it waits a programmable settle time, then compares the two models' outputs and counts mismatches. It also builds a 16-bit map of the secondary output `p`, and reports pass/fail. It replaces hand-written per-vector stimulus lists in the q3 benches.

## Interface
- `SETTLE`, default 2: settle cycles between applying a vector and sampling it. Legal range 1..15.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a sweep; ignored unless the state is IDLE
- `abort`  in  1  terminates the sweep; the state returns to IDLE on the next edge
- `x`, `y`, `z`, `m`  out  1 each  registered stimulus; `x` = vec[3], `y` = vec[2], `z` = vec[1], `m` = vec[0]
- `s_in`  in  1  gate-model output `s`
- `p_in`  in  1  gate-model output `p`
- `l_in`  in  1  UDP-model output `l`, expected equal to `s_in`
- `busy`  out  1  high while in WAIT or CHECK
- `done`  out  1  one-cycle pulse when a sweep completes normally
- `pass`  out  1  high when the last completed sweep had `err_cnt` == 0
- `err_cnt`  out  5  number of mismatching vectors in the current or last sweep, range 0..16
- `first_err_vec`  out  4  vector index of the first mismatch
- `p_map`  out  16  bit i = `p_in` sampled for vector i

## Operation
- States: IDLE, WAIT, CHECK, DONE. All outputs are registered.
- IDLE:
  - On `start`: vec <= 0, scnt <= 0, `err_cnt` <= 0, `first_err_vec` <= 0, `p_map` <= 0, `pass` <= 0; go to WAIT.
  - Otherwise `pass` and the result registers hold their values.
- WAIT:
  - `x`..`m` drive vec. scnt increments each cycle.
  - When scnt == SETTLE-1, go to CHECK.
- CHECK (one cycle):
  - Mismatch is `l_in !== s_in`. X or Z on either input counts as a mismatch.
  - On mismatch, `err_cnt` increments. If `err_cnt` was 0, `first_err_vec` <= vec.
  - `p_map[vec]` <= `p_in`. An X on `p_in` is stored as is.
  - If vec == 15, go to DONE. Otherwise vec <= vec+1, scnt <= 0, go to WAIT.
- DONE (one cycle):
  - `done` = 1, `pass` <= (`err_cnt` == 0).
  - Go to IDLE. Stimulus holds 4'hF.
- `abort`:
  - In WAIT or CHECK, `abort` wins over every transition and goes to IDLE.
  - No `done` pulse, `pass` = 0.
  - `err_cnt`, `first_err_vec` and `p_map` hold their partial values. Stimulus holds its last vector.
  - In IDLE or DONE, `abort` has no effect.
- `start` outside IDLE is ignored, including in DONE.
- `start` and `abort` together in IDLE: `start` is taken.
- `err_cnt` is 5 bits and cannot overflow (maximum 16).

## Timing
- Reset values: `x` = `y` = `z` = `m` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `first_err_vec` = 0, `p_map` = 0, state IDLE, vec = 0, scnt = 0.
- `rst` at any point, including mid-sweep, restores reset values on the next edge and overrides `start` and `abort`.
- Let E0 be the edge that samples `start`.
  - Vector n appears on `x`..`m` after edge E0 + n·(SETTLE+1).
  - Vector n is sampled at edge E0 + n·(SETTLE+1) + SETTLE + 1.
  - The sampled inputs therefore see SETTLE+1 cycles of stable stimulus.
- `done` is high for the single cycle after edge E0 + 16·(SETTLE+1); `pass` is valid from that cycle on.
- Total sweep length is 16·(SETTLE+1)+1 cycles: 49 cycles at SETTLE = 2.
- `busy` rises after E0 and falls when DONE is entered.
- Back-to-back sweeps: the earliest next `start` is sampled in the cycle after `done`.

## Test plan
- Matched models (`l_in` tied to `s_in` = x^y^z^m), SETTLE = 2, `start` pulse:
  - stimulus runs 0..15 in x-MSB order, each vector held 3 cycles;
  - `done` pulses once 49 cycles after the start edge;
  - `pass` = 1, `err_cnt` = 0, `p_map` = bits of the `p` function.
- Injected mismatches at vectors 5 and 12:
  - `err_cnt` = 2, `first_err_vec` = 5, `pass` = 0.
- `l_in` = X for vector 3 only:
  - `err_cnt` = 1, `first_err_vec` = 3.
- `abort` asserted during CHECK of vector 7:
  - state goes to IDLE, `done` never pulses, `pass` = 0, `busy` = 0;
  - `p_map` bits 8..15 remain 0.
- `rst` asserted at vector 9, plus `start` pulses while busy:
  - `rst` restores all reset values on the next edge;
  - `start` pulses during a sweep do not restart it.
- SETTLE = 1 and SETTLE = 15:
  - sweep lengths are 33 and 257 cycles;
  - each sample occurs exactly SETTLE+1 cycles after its vector is applied.
